// File: rtl/lc3_debug_arbiter.sv
// Round-robin sequencer sharing the LC-3 register-read and direct-memory debug ports between two requesters.
// Latency: gnt and strobe 1 cycle after accept, rsp_valid LAT+2 cycles after accept, back in IDLE at LAT+3.
// Backpressure: one transaction in flight; req levels are sampled only in IDLE and held by the requester until gnt.
module lc3_debug_arbiter #(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned REG_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_a,
    input  logic        req_b,
    input  logic        a_is_mem,
    input  logic        b_is_mem,
    input  logic [15:0] a_addr,
    input  logic [15:0] b_addr,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        busy,
    output logic        clk_r,
    output logic [2:0]  SR_r,
    input  logic [15:0] Out_r,
    output logic        clk_direct,
    output logic [15:0] address_in_direct,
    input  logic [15:0] mem_out_direct
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] MEM_CNT = 4'(MEM_LAT - 1);
    localparam logic [3:0] REG_CNT = 4'(REG_LAT - 1);

    state_t      state_q;
    state_t      state_d;
    logic        last_b_q;
    logic        is_mem_q;
    logic [3:0]  cnt_q;

    logic        accept;
    logic        win_b;
    logic        sel_is_mem;
    logic [15:0] sel_addr;
    logic        capture;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        win_b   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    accept  = 1'b1;
                    // B wins when it is alone, or on contention when A was served last.
                    win_b   = req_b && (!req_a || !last_b_q);
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt_q == 4'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        sel_is_mem = win_b ? b_is_mem : a_is_mem;
        sel_addr   = win_b ? b_addr   : a_addr;
        capture    = (state_q == WAIT) && (cnt_q == 4'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are registered from the next-state decision so they line up with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt_a             <= 1'b0;
            gnt_b             <= 1'b0;
            clk_r             <= 1'b0;
            clk_direct        <= 1'b0;
            busy              <= 1'b0;
            rsp_valid         <= 1'b0;
            rsp_id            <= 1'b0;
            rsp_data          <= 16'h0000;
            SR_r              <= 3'd0;
            address_in_direct <= 16'h0000;
            last_b_q          <= 1'b1;
            is_mem_q          <= 1'b0;
            cnt_q             <= 4'd0;
        end else begin
            gnt_a      <= accept && !win_b;
            gnt_b      <= accept && win_b;
            clk_direct <= accept && sel_is_mem;
            clk_r      <= accept && !sel_is_mem;
            busy       <= (state_d != IDLE);
            rsp_valid  <= capture;
            // last_b_q doubles as the latched transaction id once a request is accepted.
            rsp_id     <= capture && last_b_q;

            if (accept) begin
                last_b_q          <= win_b;
                is_mem_q          <= sel_is_mem;
                address_in_direct <= sel_addr;
                SR_r              <= sel_addr[2:0];
            end

            if (state_q == ISSUE) begin
                cnt_q <= is_mem_q ? MEM_CNT : REG_CNT;
            end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end

            if (capture) begin
                rsp_data <= is_mem_q ? mem_out_direct : Out_r;
            end
        end
    end

endmodule

// File: tb/tb_lc3_debug_arbiter.sv
// Directed bench for lc3_debug_arbiter: default-latency instance plus a MEM_LAT=15 instance.
module tb_lc3_debug_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        req_a, req_b, a_is_mem, b_is_mem;
    logic [15:0] a_addr, b_addr, out_r, mem_out;
    logic        gnt_a, gnt_b, rsp_valid, rsp_id, busy, clk_r, clk_direct;
    logic [15:0] rsp_data, address_in_direct;
    logic [2:0]  sr_r;

    logic        l_req_a;
    logic [15:0] l_addr, l_mem_out;
    logic        l_gnt_a, l_gnt_b, l_rsp_valid, l_rsp_id, l_busy, l_clk_r, l_clk_direct;
    logic [15:0] l_rsp_data, l_address;
    logic [2:0]  l_sr_r;

    int n_cmp = 0;
    int n_bad = 0;

    lc3_debug_arbiter dut (
        .clk(clk), .reset_n(rst_n),
        .req_a(req_a), .req_b(req_b), .a_is_mem(a_is_mem), .b_is_mem(b_is_mem),
        .a_addr(a_addr), .b_addr(b_addr),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy), .clk_r(clk_r), .SR_r(sr_r), .Out_r(out_r),
        .clk_direct(clk_direct), .address_in_direct(address_in_direct), .mem_out_direct(mem_out)
    );

    lc3_debug_arbiter #(.MEM_LAT(15), .REG_LAT(1)) dut_l15 (
        .clk(clk), .reset_n(rst_n),
        .req_a(l_req_a), .req_b(1'b0), .a_is_mem(1'b1), .b_is_mem(1'b0),
        .a_addr(l_addr), .b_addr(16'h0000),
        .gnt_a(l_gnt_a), .gnt_b(l_gnt_b), .rsp_valid(l_rsp_valid), .rsp_id(l_rsp_id),
        .rsp_data(l_rsp_data), .busy(l_busy), .clk_r(l_clk_r), .SR_r(l_sr_r), .Out_r(16'h0000),
        .clk_direct(l_clk_direct), .address_in_direct(l_address), .mem_out_direct(l_mem_out)
    );

    // Protocol monitors, one per instance.
    int   viol0 = 0;
    int   viol1 = 0;
    logic out0 = 1'b0, strb0_q = 1'b0;
    logic out1 = 1'b0, strb1_q = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            out0 = 1'b0;
            strb0_q = 1'b0;
        end else begin
            if (clk_r && clk_direct) viol0++;
            if (gnt_a && gnt_b) viol0++;
            if ((gnt_a || gnt_b) != (clk_r || clk_direct)) viol0++;
            if ((gnt_a || gnt_b || rsp_valid) && !busy) viol0++;
            if ((clk_r || clk_direct) && strb0_q) viol0++;
            if (gnt_a || gnt_b) begin
                if (out0) viol0++;
                out0 = 1'b1;
            end
            if (rsp_valid) begin
                if (!out0) viol0++;
                out0 = 1'b0;
            end
            strb0_q = clk_r || clk_direct;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            out1 = 1'b0;
            strb1_q = 1'b0;
        end else begin
            if (l_clk_r && l_clk_direct) viol1++;
            if (l_gnt_a && l_gnt_b) viol1++;
            if ((l_gnt_a || l_gnt_b) != (l_clk_r || l_clk_direct)) viol1++;
            if ((l_gnt_a || l_gnt_b || l_rsp_valid) && !l_busy) viol1++;
            if ((l_clk_r || l_clk_direct) && strb1_q) viol1++;
            if (l_gnt_a || l_gnt_b) begin
                if (out1) viol1++;
                out1 = 1'b1;
            end
            if (l_rsp_valid) begin
                if (!out1) viol1++;
                out1 = 1'b0;
            end
            strb1_q = l_clk_r || l_clk_direct;
        end
    end

    // Observation record of the last transaction on the default instance.
    int          ob_gnt_cyc, ob_gnts, ob_strb_cyc, ob_strbs, ob_rsp_cyc, ob_addr_bad;
    logic        ob_gnt_b, ob_strb_mem, ob_rsp_id;
    logic [15:0] ob_rsp_dat;

    // Cycle 0 is the cycle in which the request is presented and sampled.
    task automatic txn0(input logic ra, input logic rb, input logic am, input logic bm,
                        input logic [15:0] aa, input logic [15:0] ba, input logic hold,
                        input int chg_cyc, input logic [15:0] chg_val, input logic [15:0] exp_addr);
        ob_gnt_cyc = -1; ob_gnts = 0; ob_strb_cyc = -1; ob_strbs = 0;
        ob_rsp_cyc = -1; ob_addr_bad = 0;
        ob_gnt_b = 1'b0; ob_strb_mem = 1'b0; ob_rsp_id = 1'b0; ob_rsp_dat = 16'h0000;
        @(posedge clk); #1;
        req_a = ra; req_b = rb; a_is_mem = am; b_is_mem = bm; a_addr = aa; b_addr = ba;
        for (int j = 0; j < 40 && ob_rsp_cyc < 0; j++) begin
            @(negedge clk);
            if (gnt_a || gnt_b) begin
                ob_gnts++;
                if (ob_gnt_cyc < 0) begin
                    ob_gnt_cyc = j;
                    ob_gnt_b = gnt_b;
                end
                if (!hold) begin
                    if (gnt_a) req_a = 1'b0;
                    if (gnt_b) req_b = 1'b0;
                end
            end
            if (clk_r || clk_direct) begin
                ob_strbs++;
                if (ob_strb_cyc < 0) begin
                    ob_strb_cyc = j;
                    ob_strb_mem = clk_direct;
                end
            end
            if (j >= 1 && address_in_direct !== exp_addr) ob_addr_bad++;
            if (rsp_valid) begin
                ob_rsp_cyc = j;
                ob_rsp_dat = rsp_data;
                ob_rsp_id = rsp_id;
            end
            if (j == chg_cyc) mem_out = chg_val;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_a = 0; req_b = 0; a_is_mem = 0; b_is_mem = 0; a_addr = 0; b_addr = 0;
        out_r = 0; mem_out = 0; l_req_a = 0; l_addr = 0; l_mem_out = 0;
        @(negedge clk);
        n_cmp++;
        if ({gnt_a, gnt_b, rsp_valid, rsp_id, busy, clk_r, clk_direct, sr_r, rsp_data, address_in_direct} !== 42'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {gnt_a, gnt_b, rsp_valid, rsp_id, busy, clk_r, clk_direct, sr_r, rsp_data, address_in_direct});
        end
        n_cmp++;
        if ({l_gnt_a, l_gnt_b, l_rsp_valid, l_rsp_id, l_busy, l_clk_r, l_clk_direct, l_sr_r, l_rsp_data, l_address} !== 42'd0) begin
            n_bad++;
            $display("FAIL reset_outputs_l15: got %h expected 0",
                     {l_gnt_a, l_gnt_b, l_rsp_valid, l_rsp_id, l_busy, l_clk_r, l_clk_direct, l_sr_r, l_rsp_data, l_address});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_wait;
        int cnt;
        @(posedge clk); #1;
        req_a = 1; a_is_mem = 1; a_addr = 16'h3000; mem_out = 16'h5555;
        @(negedge clk);
        @(negedge clk);
        req_a = 0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || address_in_direct !== 16'h3000) begin
            n_bad++;
            $display("FAIL pre_reset_wait: busy=%b addr=%h expected busy=1 addr=3000", busy, address_in_direct);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({gnt_a, gnt_b, rsp_valid, rsp_id, busy, clk_r, clk_direct, sr_r, rsp_data, address_in_direct} !== 42'd0) begin
            n_bad++;
            $display("FAIL reset_mid_wait: got %h expected 0",
                     {gnt_a, gnt_b, rsp_valid, rsp_id, busy, clk_r, clk_direct, sr_r, rsp_data, address_in_direct});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid || gnt_a || gnt_b) cnt++;
        end
        n_cmp++;
        if (cnt !== 0) begin
            n_bad++;
            $display("FAIL aborted_no_rsp: got %0d pulses expected 0", cnt);
        end
    endtask

    task automatic test_mem_read;
        mem_out = 16'hDEAD;
        txn0(1, 0, 1, 0, 16'h3000, 16'h0000, 0, 3, 16'h1234, 16'h3000);
        n_cmp++;
        if (ob_gnt_cyc !== 1 || ob_gnt_b !== 1'b0 || ob_gnts !== 1) begin
            n_bad++;
            $display("FAIL mem_gnt: cyc=%0d b=%b n=%0d expected cyc=1 b=0 n=1", ob_gnt_cyc, ob_gnt_b, ob_gnts);
        end
        n_cmp++;
        if (ob_strb_cyc !== 1 || ob_strb_mem !== 1'b1 || ob_strbs !== 1) begin
            n_bad++;
            $display("FAIL mem_strobe: cyc=%0d mem=%b n=%0d expected cyc=1 mem=1 n=1", ob_strb_cyc, ob_strb_mem, ob_strbs);
        end
        n_cmp++;
        if (ob_rsp_cyc !== 4 || ob_rsp_id !== 1'b0 || ob_rsp_dat !== 16'h1234) begin
            n_bad++;
            $display("FAIL mem_rsp: cyc=%0d id=%b data=%h expected cyc=4 id=0 data=1234", ob_rsp_cyc, ob_rsp_id, ob_rsp_dat);
        end
        n_cmp++;
        if (ob_addr_bad !== 0) begin
            n_bad++;
            $display("FAIL mem_addr_stable: got %0d bad cycles expected 0", ob_addr_bad);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 16'h1234 || address_in_direct !== 16'h3000) begin
            n_bad++;
            $display("FAIL mem_idle: busy=%b vld=%b data=%h addr=%h expected 0 0 1234 3000",
                     busy, rsp_valid, rsp_data, address_in_direct);
        end
        mem_out = 16'h9999;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (rsp_data !== 16'h1234) begin
            n_bad++;
            $display("FAIL rsp_data_hold: got %h expected 1234", rsp_data);
        end
    endtask

    task automatic test_reg_read;
        out_r = 16'hBEEF;
        txn0(0, 1, 0, 0, 16'h0000, 16'hFFF5, 0, -1, 16'h0000, 16'hFFF5);
        n_cmp++;
        if (ob_gnt_cyc !== 1 || ob_gnt_b !== 1'b1 || ob_gnts !== 1) begin
            n_bad++;
            $display("FAIL reg_gnt: cyc=%0d b=%b n=%0d expected cyc=1 b=1 n=1", ob_gnt_cyc, ob_gnt_b, ob_gnts);
        end
        n_cmp++;
        if (ob_strb_cyc !== 1 || ob_strb_mem !== 1'b0 || ob_strbs !== 1) begin
            n_bad++;
            $display("FAIL reg_strobe: cyc=%0d mem=%b n=%0d expected cyc=1 mem=0 n=1", ob_strb_cyc, ob_strb_mem, ob_strbs);
        end
        n_cmp++;
        if (ob_rsp_cyc !== 3 || ob_rsp_id !== 1'b1 || ob_rsp_dat !== 16'hBEEF) begin
            n_bad++;
            $display("FAIL reg_rsp: cyc=%0d id=%b data=%h expected cyc=3 id=1 data=beef", ob_rsp_cyc, ob_rsp_id, ob_rsp_dat);
        end
        n_cmp++;
        if (sr_r !== 3'd5 || ob_addr_bad !== 0) begin
            n_bad++;
            $display("FAIL reg_index: sr_r=%0d bad=%0d expected sr_r=5 bad=0", sr_r, ob_addr_bad);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        logic exp_b;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_r = 16'h0A0B;
        for (int k = 0; k < 4; k++) begin
            exp_b = (k % 2) == 1;
            txn0(1, 1, 0, 0, 16'h0011, 16'h0022, 1, -1, 16'h0000, exp_b ? 16'h0022 : 16'h0011);
            n_cmp++;
            if (ob_gnt_b !== exp_b || ob_rsp_id !== exp_b || ob_gnt_cyc !== 1 || ob_rsp_cyc !== 3 || ob_addr_bad !== 0) begin
                n_bad++;
                $display("FAIL rr_txn%0d: gnt_b=%b id=%b gcyc=%0d rcyc=%0d bad=%0d expected gnt_b=%b id=%b gcyc=1 rcyc=3 bad=0",
                         k, ob_gnt_b, ob_rsp_id, ob_gnt_cyc, ob_rsp_cyc, ob_addr_bad, exp_b, exp_b);
            end
        end
        req_a = 0;
        req_b = 0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rr_drain: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_single_and_contention;
        txn0(0, 1, 0, 0, 16'h0000, 16'h0007, 0, -1, 16'h0000, 16'h0007);
        n_cmp++;
        if (ob_gnt_b !== 1'b1 || ob_rsp_id !== 1'b1) begin
            n_bad++;
            $display("FAIL lone_b_repeat: gnt_b=%b id=%b expected 1 1", ob_gnt_b, ob_rsp_id);
        end
        txn0(1, 1, 0, 0, 16'h0006, 16'h0007, 0, -1, 16'h0000, 16'h0006);
        n_cmp++;
        if (ob_gnt_b !== 1'b0 || ob_rsp_id !== 1'b0) begin
            n_bad++;
            $display("FAIL contention_after_b: gnt_b=%b id=%b expected 0 0", ob_gnt_b, ob_rsp_id);
        end
        txn0(0, 1, 0, 0, 16'h0006, 16'h0007, 0, -1, 16'h0000, 16'h0007);
        n_cmp++;
        if (ob_gnt_b !== 1'b1 || ob_gnt_cyc !== 1 || ob_rsp_id !== 1'b1) begin
            n_bad++;
            $display("FAIL waiting_b_served: gnt_b=%b gcyc=%0d id=%b expected 1 1 1", ob_gnt_b, ob_gnt_cyc, ob_rsp_id);
        end
        @(negedge clk);
    endtask

    task automatic test_done_window;
        int r;
        logic id;
        txn0(1, 0, 0, 0, 16'h0003, 16'h0000, 0, -1, 16'h0000, 16'h0003);
        req_b = 1; b_is_mem = 1; b_addr = 16'h0100;
        @(negedge clk);
        n_cmp++;
        if (gnt_b !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL done_no_accept: gnt_b=%b busy=%b expected 0 0", gnt_b, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (gnt_b !== 1'b1 || clk_direct !== 1'b1 || address_in_direct !== 16'h0100) begin
            n_bad++;
            $display("FAIL idle_accept: gnt_b=%b strobe=%b addr=%h expected 1 1 0100", gnt_b, clk_direct, address_in_direct);
        end
        req_b = 0;
        r = -1;
        id = 1'b0;
        for (int j = 2; j < 12 && r < 0; j++) begin
            @(negedge clk);
            if (rsp_valid) begin
                r = j;
                id = rsp_id;
            end
        end
        n_cmp++;
        if (r !== 4 || id !== 1'b1) begin
            n_bad++;
            $display("FAIL done_window_rsp: cyc=%0d id=%b expected cyc=4 id=1", r, id);
        end
        @(negedge clk);
    endtask

    task automatic test_lat15;
        int g, r, strbs;
        logic [15:0] d;
        g = -1; r = -1; strbs = 0; d = 16'h0000;
        l_mem_out = 16'hAAAA;
        @(posedge clk); #1;
        l_req_a = 1;
        l_addr = 16'h4000;
        for (int j = 0; j < 30 && r < 0; j++) begin
            @(negedge clk);
            if (l_gnt_a) begin
                if (g < 0) g = j;
                l_req_a = 0;
            end
            if (l_clk_direct) strbs++;
            if (l_rsp_valid) begin
                r = j;
                d = l_rsp_data;
            end
            if (j == 15) l_mem_out = 16'h1111;
            if (j == 17) l_mem_out = 16'h2222;
        end
        n_cmp++;
        if (g !== 1 || strbs !== 1 || l_address !== 16'h4000) begin
            n_bad++;
            $display("FAIL l15_issue: gcyc=%0d strobes=%0d addr=%h expected 1 1 4000", g, strbs, l_address);
        end
        n_cmp++;
        if (r !== 17 || d !== 16'h1111) begin
            n_bad++;
            $display("FAIL l15_rsp: cyc=%0d data=%h expected cyc=17 data=1111", r, d);
        end
        @(negedge clk);
        n_cmp++;
        if (l_rsp_data !== 16'h1111 || l_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL l15_after_capture: data=%h busy=%b expected 1111 0", l_rsp_data, l_busy);
        end
    endtask

    task automatic test_protocol;
        n_cmp++;
        if (viol0 !== 0) begin
            n_bad++;
            $display("FAIL protocol_dut: got %0d violations expected 0", viol0);
        end
        n_cmp++;
        if (viol1 !== 0) begin
            n_bad++;
            $display("FAIL protocol_l15: got %0d violations expected 0", viol1);
        end
    endtask

    initial begin
        test_reset;
        test_reset_mid_wait;
        test_mem_read;
        test_reg_read;
        test_round_robin;
        test_single_and_contention;
        test_done_window;
        test_lat15;
        test_protocol;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1);
    end

endmodule
